// File: rtl/dbg_load_run_ctrl_if.sv
// Command and instruction-memory port bundle between the SPI slave, the
// debug load/run controller and the instruction memory.
interface dbg_load_run_ctrl_if #(
  parameter int NB_BITS   = 32,
  parameter int RAM_DEPTH = 10
);
  logic [NB_BITS-1:0]   i_cmd;
  logic                 i_cmd_valid;
  logic [RAM_DEPTH-1:0] o_addr;
  logic [NB_BITS-1:0]   o_data;
  logic                 o_wea;

  modport master (
    output i_cmd, i_cmd_valid,
    input  o_addr, o_data, o_wea
  );

  modport slave (
    input  i_cmd, i_cmd_valid,
    output o_addr, o_data, o_wea
  );
endinterface

// File: rtl/dbg_load_run_ctrl.sv
// Debug command sequencer: decodes SPI command words into instruction-memory
// writes, gates the core clock-enable for run/step and selects readback.
module dbg_load_run_ctrl #(
  parameter int NB_BITS   = 32,
  parameter int RAM_DEPTH = 10,
  parameter int NB_STEP   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  dbg_load_run_ctrl_if.slave bus,
  input  logic               i_halt,
  output logic               o_cpu_en,
  output logic               o_debug,
  output logic [1:0]         o_rd_sel,
  output logic               o_rd_valid,
  output logic               o_busy,
  output logic               o_err
);

  localparam int HALF = NB_BITS / 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RUN   = 2'd2,
    ST_STEP  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP      = 3'b000,
    OP_SET_ADDR = 3'b001,
    OP_DATA_LO  = 3'b010,
    OP_DATA_HI  = 3'b011,
    OP_RUN      = 3'b100,
    OP_STEP     = 3'b101,
    OP_STOP     = 3'b110,
    OP_READ     = 3'b111
  } opcode_e;

  state_e               state_q, state_d;
  logic [RAM_DEPTH-1:0] addr_q, addr_d;
  logic [NB_BITS-1:0]   data_q, data_d;
  logic [1:0]           rd_sel_q, rd_sel_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 err_q, err_d;
  logic [NB_STEP-1:0]   count_q, count_d;

  opcode_e opcode;
  logic    cmd_stop;
  logic    cmd_illegal_busy;
  logic    unused_cmd_bits;

  assign opcode          = opcode_e'(bus.i_cmd[NB_BITS-1 -: 3]);
  assign cmd_stop        = bus.i_cmd_valid && (opcode == OP_STOP);
  // While the core owns the memory only READ, STOP and NOP are meaningful.
  assign cmd_illegal_busy = bus.i_cmd_valid && (opcode != OP_NOP) &&
                            (opcode != OP_STOP) && (opcode != OP_READ);
  assign unused_cmd_bits = ^bus.i_cmd[NB_BITS-4:HALF];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      rd_sel_q   <= 2'b00;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_sel_q   <= rd_sel_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_sel_d   = rd_sel_q;
    rd_valid_d = 1'b0;
    err_d      = err_q;
    count_d    = count_q;

    if (bus.i_cmd_valid && (opcode == OP_READ) && (state_q != ST_WRITE)) begin
      rd_sel_d   = (bus.i_cmd[1:0] == 2'b11) ? 2'b00 : bus.i_cmd[1:0];
      rd_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.i_cmd_valid) begin
          case (opcode)
            OP_SET_ADDR: addr_d = bus.i_cmd[RAM_DEPTH-1:0];
            OP_DATA_LO:  data_d[HALF-1:0] = bus.i_cmd[HALF-1:0];
            OP_DATA_HI: begin
              data_d[NB_BITS-1:HALF] = bus.i_cmd[HALF-1:0];
              state_d                = ST_WRITE;
            end
            OP_RUN:      state_d = ST_RUN;
            OP_STEP: begin
              count_d = bus.i_cmd[NB_STEP-1:0];
              if (bus.i_cmd[NB_STEP-1:0] != '0) state_d = ST_STEP;
            end
            default: ;
          endcase
        end
      end
      ST_WRITE: begin
        // Memory captures addr/data this cycle; advance for the next burst word.
        addr_d  = addr_q + 1'b1;
        state_d = ST_IDLE;
        if (bus.i_cmd_valid) err_d = 1'b1;
      end
      ST_RUN: begin
        if (i_halt || cmd_stop) state_d = ST_IDLE;
        if (cmd_illegal_busy)   err_d   = 1'b1;
      end
      ST_STEP: begin
        count_d = count_q - 1'b1;
        if (i_halt || cmd_stop || (count_q == NB_STEP'(1))) state_d = ST_IDLE;
        if (cmd_illegal_busy) err_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset drops them at once.
  assign bus.o_addr = addr_q;
  assign bus.o_data = data_q;
  assign bus.o_wea  = (state_q == ST_WRITE);
  assign o_cpu_en   = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign o_busy     = o_cpu_en;
  assign o_debug    = !o_cpu_en;
  assign o_rd_sel   = rd_sel_q;
  assign o_rd_valid = rd_valid_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_dbg_load_run_ctrl.sv
// Directed bench for dbg_load_run_ctrl: memory load with address wrap,
// step/run gating, illegal-command flag, readback select and async reset.
module tb_dbg_load_run_ctrl;

  localparam int NB_BITS   = 32;
  localparam int RAM_DEPTH = 10;
  localparam int NB_STEP   = 16;

  localparam logic [2:0] OP_NOP      = 3'b000;
  localparam logic [2:0] OP_SET_ADDR = 3'b001;
  localparam logic [2:0] OP_DATA_LO  = 3'b010;
  localparam logic [2:0] OP_DATA_HI  = 3'b011;
  localparam logic [2:0] OP_RUN      = 3'b100;
  localparam logic [2:0] OP_STEP     = 3'b101;
  localparam logic [2:0] OP_STOP     = 3'b110;
  localparam logic [2:0] OP_READ     = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       halt;
  logic       cpu_en, debug, rd_valid, busy, err;
  logic [1:0] rd_sel;
  int         checks = 0;
  int         errors = 0;

  dbg_load_run_ctrl_if #(.NB_BITS(NB_BITS), .RAM_DEPTH(RAM_DEPTH)) bus ();

  dbg_load_run_ctrl #(
    .NB_BITS(NB_BITS), .RAM_DEPTH(RAM_DEPTH), .NB_STEP(NB_STEP)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .bus       (bus),
    .i_halt    (halt),
    .o_cpu_en  (cpu_en),
    .o_debug   (debug),
    .o_rd_sel  (rd_sel),
    .o_rd_valid(rd_valid),
    .o_busy    (busy),
    .o_err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [28:0] arg);
    return {op, arg};
  endfunction

  // Presents one command for a single posedge; returns on the following negedge.
  task automatic send(input logic [2:0] op, input logic [28:0] arg);
    @(negedge clk);
    bus.i_cmd       = mk(op, arg);
    bus.i_cmd_valid = 1'b1;
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd       = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},   32'(bus.o_addr), 32'h0);
    check({tag, "_data"},   bus.o_data,      32'h0);
    check({tag, "_wea"},    32'(bus.o_wea),  32'h0);
    check({tag, "_cpu_en"}, 32'(cpu_en),     32'h0);
    check({tag, "_debug"},  32'(debug),      32'h1);
    check({tag, "_rd_sel"}, 32'(rd_sel),     32'h0);
    check({tag, "_rd_vld"}, 32'(rd_valid),   32'h0);
    check({tag, "_busy"},   32'(busy),       32'h0);
    check({tag, "_err"},    32'(err),        32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n           = 1'b0;
    halt            = 1'b0;
    bus.i_cmd       = '0;
    bus.i_cmd_valid = 1'b0;
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Load 0x12345678 at 0x3FE, then post-increment.
    send(OP_SET_ADDR, 29'h3FE);
    send(OP_DATA_LO,  29'h5678);
    send(OP_DATA_HI,  29'h1234);
    check("wr1_wea",  32'(bus.o_wea),  32'h1);
    check("wr1_addr", 32'(bus.o_addr), 32'h3FE);
    check("wr1_data", bus.o_data,      32'h12345678);
    @(negedge clk);
    check("wr1_wea_off", 32'(bus.o_wea),  32'h0);
    check("wr1_inc",     32'(bus.o_addr), 32'h3FF);

    // Second word at 0x3FF; address wraps to 0.
    send(OP_DATA_LO, 29'hBABE);
    send(OP_DATA_HI, 29'hCAFE);
    check("wr2_wea",  32'(bus.o_wea),  32'h1);
    check("wr2_addr", 32'(bus.o_addr), 32'h3FF);
    check("wr2_data", bus.o_data,      32'hCAFEBABE);
    @(negedge clk);
    check("wr2_wrap", 32'(bus.o_addr), 32'h000);
    check("wr2_wea_off", 32'(bus.o_wea), 32'h0);

    // Readback select, including 11 folding to 00.
    send(OP_READ, 29'h1);
    check("rd1_sel", 32'(rd_sel),   32'h1);
    check("rd1_vld", 32'(rd_valid), 32'h1);
    @(negedge clk);
    check("rd1_vld_off", 32'(rd_valid), 32'h0);
    send(OP_READ, 29'h3);
    check("rd3_sel", 32'(rd_sel),   32'h0);
    check("rd3_vld", 32'(rd_valid), 32'h1);

    // STEP 3: exactly three enable cycles.
    send(OP_STEP, 29'h3);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("step3_en%0d", i),   32'(cpu_en), 32'(i < 3));
      check($sformatf("step3_busy%0d", i), 32'(busy),   32'(i < 3));
      @(negedge clk);
    end
    check("step3_debug", 32'(debug), 32'h1);

    // STEP 0 is a no-op.
    send(OP_STEP, 29'h0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("step0_en%0d", i), 32'(cpu_en), 32'h0);
      @(negedge clk);
    end

    // RUN terminated by halt.
    send(OP_RUN, 29'h0);
    check("run_en",    32'(cpu_en), 32'h1);
    check("run_debug", 32'(debug),  32'h0);
    check("run_busy",  32'(busy),   32'h1);
    repeat (9) @(negedge clk);
    halt = 1'b1;
    check("run_en_at_halt", 32'(cpu_en), 32'h1);
    @(negedge clk);
    halt = 1'b0;
    check("halt_en",    32'(cpu_en), 32'h0);
    check("halt_busy",  32'(busy),   32'h0);
    check("halt_debug", 32'(debug),  32'h1);

    // RUN terminated by simultaneous STOP and halt.
    send(OP_RUN, 29'h0);
    check("run2_en", 32'(cpu_en), 32'h1);
    @(negedge clk);
    bus.i_cmd       = mk(OP_STOP, 29'h0);
    bus.i_cmd_valid = 1'b1;
    halt            = 1'b1;
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    halt            = 1'b0;
    check("stophalt_en",  32'(cpu_en), 32'h0);
    check("stophalt_err", 32'(err),    32'h0);
    @(negedge clk);
    check("stophalt_idle", 32'(cpu_en), 32'h0);

    // Illegal command while running, then READ while running.
    send(OP_RUN, 29'h0);
    send(OP_NOP, 29'h0);
    check("nop_run_err", 32'(err), 32'h0);
    send(OP_DATA_LO, 29'hFFFF);
    check("ill_data", bus.o_data,  32'hCAFEBABE);
    check("ill_err",  32'(err),    32'h1);
    check("ill_en",   32'(cpu_en), 32'h1);
    send(OP_READ, 29'h2);
    check("rdrun_sel",  32'(rd_sel),   32'h2);
    check("rdrun_vld",  32'(rd_valid), 32'h1);
    @(negedge clk);
    check("rdrun_vld_off", 32'(rd_valid), 32'h0);
    check("rdrun_busy",    32'(busy),     32'h1);
    send(OP_STOP, 29'h0);
    check("stop_en",     32'(cpu_en), 32'h0);
    check("err_sticky",  32'(err),    32'h1);

    // Async reset mid-RUN.
    send(OP_RUN, 29'h0);
    check("run3_en", 32'(cpu_en), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("arst_run");
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset mid-WRITE discards the pending write.
    send(OP_SET_ADDR, 29'h155);
    send(OP_DATA_LO,  29'hAAAA);
    send(OP_DATA_HI,  29'h5555);
    check("wr3_wea", 32'(bus.o_wea), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("arst_wr");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_wea",  32'(bus.o_wea),  32'h0);
    check("post_rst_addr", 32'(bus.o_addr), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbg_load_run_ctrl.md
Name: dbg_load_run_ctrl

Overview:
- Command sequencer between the SPI slave and the MIPS core.
- Decodes 32-bit command words received over SPI into instruction-memory load sequences, and drives the memory port address, data and write enable.
- Gates the CPU clock-enable for free run and single/multi-step execution, and selects the readback source (PC, latched PC, latched instruction) returned to the SPI slave.

Parameters:
NB_BITS, 32, command/data word width
RAM_DEPTH, 10, instruction memory address width
NB_STEP, 16, step counter width (taken from cmd[NB_STEP-1:0])

Ports:
i_clk  in  1  system clock, rising edge
i_rst_n  in  1  asynchronous reset, active low
i_cmd  in  NB_BITS  command word from SPI slave
i_cmd_valid  in  1  one-cycle strobe, i_cmd valid
i_halt  in  1  core reports halt instruction retired
o_addr  out  RAM_DEPTH  instruction memory address
o_data  out  NB_BITS  instruction memory write data
o_wea  out  1  instruction memory write enable
o_cpu_en  out  1  core clock-enable
o_debug  out  1  1 = debug mode (memory owned by loader)
o_rd_sel  out  2  readback select: 00 PC, 01 latched PC, 10 latched instr
o_rd_valid  out  1  one-cycle pulse, readback select updated
o_busy  out  1  1 in RUN or STEP
o_err  out  1  sticky illegal-command flag

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_addr=0, o_data=0, o_wea=0, o_cpu_en=0, o_debug=1, o_rd_sel=00, o_rd_valid=0, o_busy=0, o_err=0, step count=0. Reset mid-run drops o_cpu_en immediately; a pending write is discarded.
- Opcode is cmd[31:29]; decoded only on a cycle with i_cmd_valid=1.
- Opcodes:
  - 000 NOP: no effect.
  - 001 SET_ADDR: o_addr <= cmd[RAM_DEPTH-1:0].
  - 010 DATA_LO: o_data[15:0] <= cmd[15:0].
  - 011 DATA_HI: o_data[31:16] <= cmd[15:0]; enter WRITE.
  - 100 RUN: enter RUN.
  - 101 STEP: count <= cmd[NB_STEP-1:0]; enter STEP if count != 0, else no-op.
  - 110 STOP: return to IDLE.
  - 111 READ: o_rd_sel <= cmd[1:0] (11 maps to 00); o_rd_valid=1 the next cycle for exactly one cycle.
- States:
  - IDLE: o_debug=1, o_cpu_en=0. Accepts all opcodes.
  - WRITE: lasts exactly 1 cycle; o_wea=1 with o_addr/o_data stable. Next cycle: o_addr <= o_addr+1 (wraps 2^RAM_DEPTH-1 -> 0), return to IDLE. Any i_cmd_valid during WRITE is ignored and sets o_err.
  - RUN: o_debug=0, o_busy=1, o_cpu_en=1 from the cycle after RUN is decoded. i_halt=1 or a STOP command -> IDLE next cycle, and o_cpu_en=0 in that same next cycle.
  - STEP: o_debug=0, o_busy=1, o_cpu_en=1 for exactly count cycles, then IDLE. i_halt or STOP ends the sequence early.
- Commands in RUN/STEP:
  - READ is allowed.
  - SET_ADDR, DATA_LO, DATA_HI, RUN, STEP and NOP are ignored and set o_err, except NOP, which is harmless.
- o_err clears only on reset.
- Simultaneous i_halt and STOP: single transition to IDLE, no error.
- i_halt in IDLE or WRITE: ignored.
- o_wea is never asserted outside WRITE. Write latency from the DATA_HI strobe to o_wea is 1 cycle.

Test Plan:
- Reset, then SET_ADDR 0x3FE, DATA_LO 0x5678, DATA_HI 0x1234 -> one cycle later o_wea=1, o_addr=0x3FE, o_data=0x12345678; following cycle o_addr=0x3FF.
- Repeat the write from 0x3FF -> o_wea at 0x3FF, then o_addr wraps to 0x000.
- STEP with count 3 -> o_cpu_en high exactly 3 consecutive cycles, o_busy likewise, back to IDLE with o_debug=1. STEP with count 0 -> o_cpu_en never asserts.
- RUN, then i_halt pulse after 10 cycles -> o_cpu_en low in the cycle after i_halt. Second run: STOP and i_halt in the same cycle -> IDLE, o_err=0.
- DATA_LO issued during RUN -> o_data unchanged, o_err=1 sticky. READ 10 during RUN -> o_rd_sel=10, o_rd_valid single pulse.
- Deassert i_rst_n asynchronously mid-RUN and mid-WRITE -> o_cpu_en and o_wea fall without a clock edge; all outputs at reset values.
